// File: rtl/sop_sweep_if.sv
// Handshake, drive/sample and readback signals between the SoP sweep sequencer and its host.
// SOP_SWEEP_CMP_EN adds the reference select and the per-function mismatch flags.
interface sop_sweep_if #(
  parameter int N_FUNC = 5,
  parameter int N_IN   = 4
);
  logic                 start;
  logic                 abort;
  logic [N_IN-1:0]      vec_out;
  logic [N_FUNC-1:0]    func_in;
  logic                 busy;
  logic                 done;
  logic [2:0]           rd_sel;
  logic [2**N_IN-1:0]   rd_table;
`ifdef SOP_SWEEP_CMP_EN
  logic [2:0]           cmp_ref;
  logic [N_FUNC-1:0]    mismatch;

  modport master (
    output start, abort, func_in, rd_sel, cmp_ref,
    input  vec_out, busy, done, rd_table, mismatch
  );

  modport slave (
    input  start, abort, func_in, rd_sel, cmp_ref,
    output vec_out, busy, done, rd_table, mismatch
  );
`else
  modport master (
    output start, abort, func_in, rd_sel,
    input  vec_out, busy, done, rd_table
  );

  modport slave (
    input  start, abort, func_in, rd_sel,
    output vec_out, busy, done, rd_table
  );
`endif
endinterface

// File: rtl/sop_sweep_ctrl.sv
// Sweeps the input vector of a SoP bank through all 2**N_IN codes and captures one truth table per function.
// SOP_SWEEP_CMP_EN adds a combinational equivalence check of every table against a selected reference.
//
// state  | meaning
// IDLE   | no sweep yet, or aborted; tables retained
// WAIT   | vec_out driven with idx, counting settle cycles
// SAMPLE | func_in captured into bit idx of every table
// DONE   | sweep complete; tables and vec_out held
module sop_sweep_ctrl #(
  parameter int N_FUNC = 5,
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input logic       clk,
  input logic       rst_n,
  sop_sweep_if.slave bus
);

  localparam int N_VEC = 2**N_IN;
  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx, idx_nxt;
  logic [N_IN-1:0]   vec, vec_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              tbl_clear;
  logic              tbl_write;
  logic [N_VEC-1:0]  tbl [N_FUNC];
  logic [N_VEC-1:0]  rd_tbl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      vec   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      vec   <= vec_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Abort is only honoured while sweeping, so an idle start+abort pair still starts.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    tbl_clear = 1'b0;
    tbl_write = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          tbl_clear = 1'b1;
          idx_nxt   = '0;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.abort) begin
          idx_nxt   = '0;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (cnt == CW'(SETTLE - 1)) begin
          state_nxt = S_SAMPLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          idx_nxt   = '0;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          tbl_write = 1'b1;
          if (idx == {N_IN{1'b1}}) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            vec_nxt   = idx + 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_WAIT;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < N_FUNC; f++) begin
        tbl[f] <= '0;
      end
    end else if (tbl_clear) begin
      for (int f = 0; f < N_FUNC; f++) begin
        tbl[f] <= '0;
      end
    end else if (tbl_write) begin
      for (int f = 0; f < N_FUNC; f++) begin
        tbl[f][idx] <= bus.func_in[f];
      end
    end
  end

  always_comb begin
    rd_tbl = '0;
    for (int f = 0; f < N_FUNC; f++) begin
      if (bus.rd_sel == 3'(f)) begin
        rd_tbl = tbl[f];
      end
    end
  end

  assign bus.vec_out  = vec;
  assign bus.busy     = (state == S_WAIT) || (state == S_SAMPLE);
  assign bus.done     = (state == S_DONE);
  assign bus.rd_table = rd_tbl;

`ifdef SOP_SWEEP_CMP_EN
  logic [N_VEC-1:0]  ref_tbl;
  logic              ref_ok;
  logic [N_FUNC-1:0] mis;

  always_comb begin
    ref_tbl = '0;
    ref_ok  = 1'b0;
    for (int f = 0; f < N_FUNC; f++) begin
      if (bus.cmp_ref == 3'(f)) begin
        ref_tbl = tbl[f];
        ref_ok  = 1'b1;
      end
    end
    mis = '0;
    for (int f = 0; f < N_FUNC; f++) begin
      mis[f] = (state == S_DONE) && ref_ok && (tbl[f] != ref_tbl);
    end
  end

  assign bus.mismatch = mis;
`endif

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Scoreboard bench for sop_sweep_ctrl: stimulus queues expected tables, a monitor checks them on done/busy events.
// Build with SOP_SWEEP_CMP_EN defined to also exercise the mismatch flags.
`timescale 1ns/1ps
module tb_sop_sweep_ctrl;

  localparam int N_FUNC = 5;
  localparam int N_IN   = 4;
  localparam int N_VEC  = 16;
  localparam int SETTLE = 1;
  localparam int LAT    = N_VEC * (SETTLE + 1);

  localparam logic [15:0] T0 = 16'h2526;
`ifdef SOP_SWEEP_CMP_EN
  localparam logic [15:0] T1 = 16'h2526;
  localparam logic [15:0] P1 = 16'h0006;
`else
  localparam logic [15:0] T1 = 16'hFFFF;
  localparam logic [15:0] P1 = 16'h001F;
`endif

  typedef enum int {K_IDLE, K_SWEEP, K_ABORT} kind_t;

  typedef struct {
    kind_t                          kind;
    logic [N_FUNC-1:0][N_VEC-1:0]   tbl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sop_sweep_if #(.N_FUNC(N_FUNC), .N_IN(N_IN)) bus ();

  sop_sweep_ctrl #(.N_FUNC(N_FUNC), .N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Bank model driven by vec_out = {x,y,w,z}
  logic x, y, w, z, f0, f1;
  assign x  = bus.vec_out[3];
  assign y  = bus.vec_out[2];
  assign w  = bus.vec_out[1];
  assign z  = bus.vec_out[0];
  assign f0 = (~w & z & ~x) | (~w & y & z) | (x & ~z & ~y) | (w & ~z & ~y);
`ifdef SOP_SWEEP_CMP_EN
  assign f1 = f0;
`else
  assign f1 = 1'b1;
`endif
  assign bus.func_in = {z, x, 1'b0, f1, f0};

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(kind_t k, logic [15:0] a, logic [15:0] b, logic [15:0] c,
                              logic [15:0] d, logic [15:0] e);
    exp_t r;
    r.kind   = k;
    r.tbl[0] = a;
    r.tbl[1] = b;
    r.tbl[2] = c;
    r.tbl[3] = d;
    r.tbl[4] = e;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  int   since  = 0;
  logic vec_ok = 1'b1;

  task automatic read_tables(output logic [7:0][15:0] t);
    for (int s = 0; s < 8; s++) begin
      bus.rd_sel = 3'(s);
      #0.4;
      t[s] = bus.rd_table;
    end
  endtask

  task automatic cmp_tables(string tag, exp_t e);
    logic [7:0][15:0] t;
    read_tables(t);
    for (int s = 0; s < 8; s++) begin
      if (s < N_FUNC) check($sformatf("%s_tbl%0d", tag, s), 32'(t[s]), 32'(e.tbl[s]));
      else            check($sformatf("%s_tbl%0d", tag, s), 32'(t[s]), 32'(0));
    end
  endtask

  initial begin
    exp_t e;
    bus.rd_sel = 3'd0;
    forever begin
      @(negedge clk);
      if (bus.busy && !busy_q) since = 0;
      else                     since++;
      if (bus.busy) begin
        if (bus.vec_out !== 4'(since / (SETTLE + 1))) vec_ok = 1'b0;
        if (!busy_q) begin
          vec_ok = (bus.vec_out === 4'd0);
`ifdef SOP_SWEEP_CMP_EN
          check("mismatch_before_done", 32'(bus.mismatch), 32'(0));
`endif
          cmp_tables("start_clear", mk(K_SWEEP, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
        end
      end
      if (bus.done && !done_q) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("done_kind", 32'(e.kind), 32'(K_SWEEP));
          check("latency", 32'(since), 32'(LAT));
          check("vec_steps", 32'(vec_ok), 32'(1));
          check("vec_hold", 32'(bus.vec_out), 32'(15));
`ifdef SOP_SWEEP_CMP_EN
          check("mismatch_done", 32'(bus.mismatch), 32'(5'b11100));
`endif
          cmp_tables("sweep", e);
        end
      end else if (!bus.busy && busy_q) begin
        if (q.size() == 0) begin
          check("unexpected_stop", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("stop_kind", 32'(e.kind), 32'(K_ABORT));
          check("stop_done", 32'(bus.done), 32'(0));
          check("stop_vec", 32'(bus.vec_out), 32'(0));
          cmp_tables("stop", e);
        end
      end else if (!bus.busy && !bus.done && q.size() > 0 && q[0].kind == K_IDLE) begin
        e = q.pop_front();
        check("idle_vec", 32'(bus.vec_out), 32'(0));
        cmp_tables("idle", e);
      end
      busy_q = bus.busy;
      done_q = bus.done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      if (bus.done) break;
      n++;
    end
    if (n >= budget) check("wait_done_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_vec(logic [3:0] v, int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      if (bus.busy && bus.vec_out == v) break;
      n++;
    end
    if (n >= budget) check("wait_vec_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef SOP_SWEEP_CMP_EN
    bus.cmp_ref = 3'd0;
`endif
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // reset / idle state
    repeat (5) @(posedge clk);
    #1;
    check("rst_vec", 32'(bus.vec_out), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    q.push_back(mk(K_IDLE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    repeat (2) @(posedge clk);

    // full sweep
    q.push_back(mk(K_SWEEP, T0, T1, 16'h0000, 16'hFF00, 16'hAAAA));
    pulse_start();
    wait_done(LAT + 10);

    // restart from DONE, with an ignored start mid-sweep
    q.push_back(mk(K_SWEEP, T0, T1, 16'h0000, 16'hFF00, 16'hAAAA));
    pulse_start();
    wait_vec(4'd3, 20);
    pulse_start();
    wait_done(LAT + 10);

    // abort in DONE has no effect
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_in_done_done", 32'(bus.done), 32'(1));
    check("abort_in_done_busy", 32'(bus.busy), 32'(0));

    // abort at vec 5
    q.push_back(mk(K_ABORT, 16'h0006, P1, 16'h0000, 16'h0000, 16'h000A));
    pulse_start();
    wait_vec(4'd5, 20);
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    repeat (2) @(posedge clk);

    // start and abort together while idle: start wins
    q.push_back(mk(K_SWEEP, T0, T1, 16'h0000, 16'hFF00, 16'hAAAA));
    @(posedge clk); #1 bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_idle_busy", 32'(bus.busy), 32'(1));
    wait_done(LAT + 10);

    // asynchronous reset at vec 9
    q.push_back(mk(K_ABORT, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    pulse_start();
    wait_vec(4'd9, 30);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_vec", 32'(bus.vec_out), 32'(0));
    check("async_rst_busy", 32'(bus.busy), 32'(0));
    check("async_rst_done", 32'(bus.done), 32'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    q.push_back(mk(K_SWEEP, T0, T1, 16'h0000, 16'hFF00, 16'hAAAA));
    pulse_start();
    wait_done(LAT + 10);

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
